// File: rtl/fp12_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp12_pkg
// Purpose : Shared constants, the 14-bit FP word type and the divider state
//           encoding used by the fp12 sequential divider.
// Revision: 1.0 - initial release
// ============================================================================
package fp12_pkg;

    localparam int WE   = 5;
    localparam int WF   = 6;
    localparam int BIAS = 15;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    typedef struct packed {
        logic [1:0]    exc;
        logic          sign;
        logic [WE-1:0] exp;
        logic [WF-1:0] frac;
    } fp12_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PREP  = 2'd1,
        S_ITER  = 2'd2,
        S_ROUND = 2'd3
    } div_state_t;

    // Returns {is_special, result_exc} for an operand class pair.
    function automatic logic [2:0] special_class(input logic [1:0] xe,
                                                 input logic [1:0] ye);
        logic [2:0] res;
        res = {1'b0, EXC_NORM};
        if (xe == EXC_NAN || ye == EXC_NAN)
            res = {1'b1, EXC_NAN};
        else if (xe == ye && xe != EXC_NORM)
            res = {1'b1, EXC_NAN};
        else if (xe == EXC_ZERO || ye == EXC_INF)
            res = {1'b1, EXC_ZERO};
        else if (xe == EXC_INF || ye == EXC_ZERO)
            res = {1'b1, EXC_INF};
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp12_round_pack.sv
`default_nettype none
// ============================================================================
// Module  : fp12_round_pack
// Purpose : Round-to-nearest-even of the 8-bit quotient, exponent range check
//           and packing of the final 14-bit result word (combinational).
// Revision: 1.0 - initial release
// ============================================================================
module fp12_round_pack
    import fp12_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp_pre,
    input  logic [7:0]  quo,
    input  logic        sticky,
    input  logic        special,
    input  logic [1:0]  special_exc,
    output logic [13:0] result
);

    logic              w_round_up;
    logic              w_carry;
    logic [WF-1:0]     w_frac;
    logic signed [7:0] w_exp;
    fp12_t             w_res;

    always_comb begin
        w_round_up = quo[0] & (sticky | quo[1]);
        // A carry out of 1.111111 wraps the fraction to 0 and bumps the exponent.
        w_carry    = (&quo[7:1]) & w_round_up;
        w_frac     = quo[6:1] + {5'b0, w_round_up};
        w_exp      = $signed(exp_pre) + $signed({7'b0, w_carry});

        w_res = '0;
        if (special) begin
            w_res.exc  = special_exc;
            w_res.sign = (special_exc == EXC_NAN) ? 1'b0 : sign;
        end else if (w_exp > 8'sd31) begin
            w_res.exc  = EXC_INF;
            w_res.sign = sign;
        end else if (w_exp < 8'sd0) begin
            w_res.exc  = EXC_ZERO;
            w_res.sign = sign;
        end else begin
            w_res.exc  = EXC_NORM;
            w_res.sign = sign;
            w_res.exp  = w_exp[WE-1:0];
            w_res.frac = w_frac;
        end
        result = w_res;
    end

endmodule
`default_nettype wire

// File: rtl/fp12_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : fp12_div_seq
// Purpose : Fixed-latency (10 cycle) sequential restoring divider for the
//           14-bit FP format. Optional divide-by-zero flag output is enabled
//           by defining FP12_DIV_DBZ_FLAG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fp12_div_seq
    import fp12_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] X,
    input  logic [13:0] Y,
    output logic [13:0] R,
    output logic        busy,
    output logic        done
`ifdef FP12_DIV_DBZ_FLAG_EN
    ,
    output logic        dbz
`endif
);

    div_state_t  r_state;
    logic [2:0]  r_cnt;
    fp12_t       r_x;
    fp12_t       r_y;
    logic [7:0]  r_rem;
    logic [6:0]  r_d;
    logic [7:0]  r_q;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic        r_special;
    logic [1:0]  r_special_exc;
    logic [13:0] r_r;
    logic        r_done;

    logic [6:0]  w_n;
    logic [6:0]  w_d;
    logic        w_pre_shift;
    logic [7:0]  w_exp_pre;
    logic [2:0]  w_special;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic        w_sticky;
    logic [13:0] w_packed;

    always_comb begin
        w_n         = {1'b1, r_x.frac};
        w_d         = {1'b1, r_y.frac};
        w_pre_shift = (w_n < w_d);
        // Modulo-256 arithmetic equals signed 8-bit two's complement here.
        w_exp_pre   = {3'b000, r_x.exp} - {3'b000, r_y.exp} + 8'(BIAS)
                      - {7'b0, w_pre_shift};
        w_special   = special_class(r_x.exc, r_y.exc);
        w_ge        = (r_rem >= {1'b0, r_d});
        w_diff      = w_ge ? (r_rem - {1'b0, r_d}) : r_rem;
        w_sticky    = (r_rem != 8'd0);
    end

    fp12_round_pack u_round_pack (
        .sign        (r_sign),
        .exp_pre     (r_exp),
        .quo         (r_q),
        .sticky      (w_sticky),
        .special     (r_special),
        .special_exc (r_special_exc),
        .result      (w_packed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_r     <= 14'h0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start)
                        r_state <= S_PREP;
                end
                S_PREP:  r_state <= S_ITER;
                S_ITER: begin
                    if (r_cnt == 3'd7)
                        r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_r     <= w_packed;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_x <= fp12_t'(X);
                    r_y <= fp12_t'(Y);
                end
            end
            S_PREP: begin
                r_rem         <= w_pre_shift ? {w_n, 1'b0} : {1'b0, w_n};
                r_d           <= w_d;
                r_exp         <= w_exp_pre;
                r_sign        <= r_x.sign ^ r_y.sign;
                r_special     <= w_special[2];
                r_special_exc <= w_special[1:0];
                r_q           <= 8'd0;
                r_cnt         <= 3'd0;
            end
            S_ITER: begin
                r_rem <= w_diff << 1;
                r_q   <= {r_q[6:0], w_ge};
                r_cnt <= r_cnt + 3'd1;
            end
            default: ;
        endcase
    end

`ifdef FP12_DIV_DBZ_FLAG_EN
    logic r_dbz;

    always_ff @(posedge clk) begin
        if (rst)
            r_dbz <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_dbz <= 1'b0;
        else if (r_state == S_ROUND)
            r_dbz <= (r_x.exc == EXC_NORM) && (r_y.exc == EXC_ZERO);
    end

    assign dbz = r_dbz;
`endif

    assign R    = r_r;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fp12_div_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp12_div_seq
// Purpose : Self-checking bench for fp12_div_seq (vector table + scoreboard).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp12_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] X;
    logic [13:0] Y;
    wire  [13:0] R;
    wire         busy;
    wire         done;
`ifdef FP12_DIV_DBZ_FLAG_EN
    wire         dbz;
`endif

    always #5 clk = ~clk;

    fp12_div_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .R     (R),
        .busy  (busy),
`ifdef FP12_DIV_DBZ_FLAG_EN
        .dbz   (dbz),
`endif
        .done  (done)
    );

    typedef struct {
        logic [13:0] x;
        logic [13:0] y;
        logic [13:0] r;
        logic        dbz;
    } vec_t;

    localparam int NV = 20;
    vec_t        vecs[NV];
    logic [14:0] sb_q[$];
    int          n_applied = 0;
    int          n_miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [13:0] x, input logic [13:0] y,
                          input logic [13:0] r, input logic d);
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        sb_q.push_back({d, r});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic await_done(input int want_lat, input string name);
        int          lat;
        logic [14:0] e;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, lat, want_lat);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
            n_applied++;
            n_miscompares++;
            $display("FAIL %s_scoreboard: got done, want no pending result", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_R"}, {18'b0, R}, {18'b0, e[13:0]});
`ifdef FP12_DIV_DBZ_FLAG_EN
            check({name, "_dbz"}, {31'b0, dbz}, {31'b0, e[14]});
`endif
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int extra;

        vecs[0]  = '{14'h1420, 14'h1400, 14'h13E0, 1'b0};  // 3/2
        vecs[1]  = '{14'h13C0, 14'h1420, 14'h1355, 1'b0};  // 1/3
        vecs[2]  = '{14'h1C20, 14'h1400, 14'h1BE0, 1'b0};  // -3/2
        vecs[3]  = '{14'h17FF, 14'h1380, 14'h2000, 1'b0};  // overflow
        vecs[4]  = '{14'h13C0, 14'h0000, 14'h2000, 1'b1};  // 1/0
        vecs[5]  = '{14'h0000, 14'h0000, 14'h3000, 1'b0};  // 0/0
        vecs[6]  = '{14'h13C0, 14'h13C8, 14'h13B2, 1'b0};  // round up
        vecs[7]  = '{14'h1000, 14'h17C0, 14'h0000, 1'b0};  // underflow
        vecs[8]  = '{14'h1800, 14'h17C0, 14'h0800, 1'b0};  // signed underflow
        vecs[9]  = '{14'h2000, 14'h1400, 14'h2000, 1'b0};  // inf/normal
        vecs[10] = '{14'h0000, 14'h2000, 14'h0000, 1'b0};  // 0/inf
        vecs[11] = '{14'h2000, 14'h2000, 14'h3000, 1'b0};  // inf/inf
        vecs[12] = '{14'h3800, 14'h1C00, 14'h3000, 1'b0};  // NaN sign cleared
        vecs[13] = '{14'h1420, 14'h2800, 14'h0800, 1'b0};  // normal/-inf
        vecs[14] = '{14'h1C20, 14'h0000, 14'h2800, 1'b1};  // -3/0
        vecs[15] = '{14'h2800, 14'h0000, 14'h2800, 1'b0};  // -inf/0
        vecs[16] = '{14'h0000, 14'h1400, 14'h0000, 1'b0};  // 0/normal
        vecs[17] = '{14'h1400, 14'h1420, 14'h1395, 1'b0};  // 2/3
        vecs[18] = '{14'h17C0, 14'h13C0, 14'h17C0, 1'b0};  // exponent 31
        vecs[19] = '{14'h1000, 14'h13C0, 14'h1000, 1'b0};  // exponent 0

        rst = 1'b1;
        start = 1'b0;
        X = '0;
        Y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_R", {18'b0, R}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
`ifdef FP12_DIV_DBZ_FLAG_EN
        check("reset_dbz", {31'b0, dbz}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: each launch lands on the edge after done.
        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].dbz);
            check($sformatf("vec%0d_busy_after_start", i), {31'b0, busy}, 32'd1);
            await_done(10, $sformatf("vec%0d", i));
        end

        // Second start at k+3 with different operands must be ignored.
        launch(14'h1420, 14'h1400, 14'h13E0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        X = 14'h13C0;
        Y = 14'h1420;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ignore_busy", {31'b0, busy}, 32'd1);
        await_done(7, "ignore");
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("ignore_single_done", extra, 32'd0);
        check("ignore_R_held", {18'b0, R}, 32'h13E0);

        // Reset at k+5 abandons the operation without a done pulse.
        @(negedge clk);
        X = 14'h13C0;
        Y = 14'h13C8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_R", {18'b0, R}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("midrst_no_done", extra, 32'd0);
        check("midrst_R_held", {18'b0, R}, 32'd0);

        launch(14'h1C20, 14'h1400, 14'h1BE0, 1'b0);
        await_done(10, "after_rst");
        launch(14'h13C0, 14'h0000, 14'h2000, 1'b1);
        await_done(10, "after_rst_dbz");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
